// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, funct fields,
// ALU selects, FSM state codes and trap causes.
package cpu_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Srl    = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Word   = 3'b010;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [31:0] InsnEcall  = 32'h0000_0073;
  localparam logic [31:0] InsnEbreak = 32'h0010_0073;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu, AluPassB
  } alu_op_e;

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [1:0] TrapNone     = 2'd0;
  localparam logic [1:0] TrapSystem   = 2'd1;
  localparam logic [1:0] TrapIllegal  = 2'd2;
  localparam logic [1:0] TrapMisalign = 2'd3;

endpackage

// File: rtl/multicycle_cpu_alu.sv
// Combinational ALU plus branch comparator; also used for effective addresses
// and jump targets.
module mc_alu
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [XLEN-1:0]   cmp_a,
  input  logic [XLEN-1:0]   cmp_b,
  input  logic [2:0]        br_f3,
  output logic [XLEN-1:0]   result,
  output logic              br_taken
);

  logic [4:0] shamt;
  logic       eq, lt, ltu;

  assign shamt = b[4:0];
  assign eq    = (cmp_a == cmp_b);
  assign lt    = ($signed(cmp_a) < $signed(cmp_b));
  assign ltu   = (cmp_a < cmp_b);

  always_comb begin
    result = '0;
    case (op)
      AluAdd:   result = a + b;
      AluSub:   result = a - b;
      AluAnd:   result = a & b;
      AluOr:    result = a | b;
      AluXor:   result = a ^ b;
      AluSll:   result = a << shamt;
      AluSrl:   result = a >> shamt;
      AluSra:   result = $signed(a) >>> shamt;
      AluSlt:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu:  result = {{(XLEN-1){1'b0}}, a < b};
      AluPassB: result = b;
      default:  result = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (br_f3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core sharing one ready-handshake memory port between
// fetch and data; halts on system instructions and faults with a cause code.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     NREGS    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic [1:0]      trap_cause
);

  localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0]     ir_q, ir_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]      cause_q, cause_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic is_reg, is_imm, is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_sys, enc_ok, use_rd, use_rs1, use_rs2, legal;
  logic [XLEN-1:0] imm_gen, alu_a, alu_b, alu_res, target, pc_plus4, next_pc;
  logic            br_taken, misalign;
  alu_op_e         alu_op;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  always_comb begin
    {is_reg, is_imm, is_lui, is_auipc, is_jal, is_jalr} = '0;
    {is_branch, is_load, is_store, is_sys, enc_ok} = '0;
    {use_rd, use_rs1, use_rs2} = '0;
    case (opcode)
      OpReg: begin
        is_reg = 1'b1;
        enc_ok = (f7 == F7Base) || (f7 == F7Alt && (f3 == F3AddSub || f3 == F3Srl));
        {use_rd, use_rs1, use_rs2} = 3'b111;
      end
      OpImm: begin
        is_imm = 1'b1;
        enc_ok = (f3 == F3Sll) ? (f7 == F7Base) :
                 (f3 == F3Srl) ? (f7 == F7Base || f7 == F7Alt) : 1'b1;
        {use_rd, use_rs1} = 2'b11;
      end
      OpLui:    begin is_lui = 1'b1;   enc_ok = 1'b1; use_rd = 1'b1; end
      OpAuipc:  begin is_auipc = 1'b1; enc_ok = 1'b1; use_rd = 1'b1; end
      OpJal:    begin is_jal = 1'b1;   enc_ok = 1'b1; use_rd = 1'b1; end
      OpJalr: begin
        is_jalr = 1'b1;
        enc_ok  = (f3 == 3'b000);
        {use_rd, use_rs1} = 2'b11;
      end
      OpBranch: begin
        is_branch = 1'b1;
        enc_ok    = (f3 != 3'b010) && (f3 != 3'b011);
        {use_rs1, use_rs2} = 2'b11;
      end
      OpLoad: begin
        is_load = 1'b1;
        enc_ok  = (f3 == F3Word);
        {use_rd, use_rs1} = 2'b11;
      end
      OpStore: begin
        is_store = 1'b1;
        enc_ok   = (f3 == F3Word);
        {use_rs1, use_rs2} = 2'b11;
      end
      OpSystem: is_sys = (ir_q == InsnEcall) || (ir_q == InsnEbreak);
      default: ;
    endcase
  end

  // Register indices beyond the implemented file are illegal, not aliased.
  assign legal = enc_ok &&
                 !(use_rd  && {27'b0, rd}  >= NREGS) &&
                 !(use_rs1 && {27'b0, rs1} >= NREGS) &&
                 !(use_rs2 && {27'b0, rs2} >= NREGS);

  always_comb begin
    if (is_lui || is_auipc)  imm_gen = {ir_q[31:12], 12'b0};
    else if (is_jal)         imm_gen = {{(XLEN-20){ir_q[31]}}, ir_q[19:12], ir_q[20],
                                        ir_q[30:21], 1'b0};
    else if (is_branch)      imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25],
                                        ir_q[11:8], 1'b0};
    else if (is_store)       imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else                     imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  end

  always_comb begin
    alu_op = AluAdd;
    if (is_lui) begin
      alu_op = AluPassB;
    end else if (is_reg || is_imm) begin
      case (f3)
        F3AddSub: alu_op = (is_reg && f7[5]) ? AluSub : AluAdd;
        F3Sll:    alu_op = AluSll;
        F3Slt:    alu_op = AluSlt;
        F3Sltu:   alu_op = AluSltu;
        F3Xor:    alu_op = AluXor;
        F3Srl:    alu_op = f7[5] ? AluSra : AluSrl;
        F3Or:     alu_op = AluOr;
        default:  alu_op = AluAnd;
      endcase
    end
  end

  assign alu_a    = (is_auipc || is_jal || is_branch) ? pc_q : a_q;
  assign alu_b    = is_reg ? b_q : imm_q;
  assign pc_plus4 = pc_q + XLEN'(32'd4);

  mc_alu #(.XLEN(XLEN)) u_alu (
    .op       (alu_op),
    .a        (alu_a),
    .b        (alu_b),
    .cmp_a    (a_q),
    .cmp_b    (b_q),
    .br_f3    (f3),
    .result   (alu_res),
    .br_taken (br_taken)
  );

  assign target = is_jalr ? {alu_res[XLEN-1:1], 1'b0} : alu_res;

  always_comb begin
    misalign = 1'b0;
    if (is_load || is_store)     misalign = (alu_res[1:0] != 2'b00);
    else if (is_jal || is_jalr)  misalign = (target[1:0] != 2'b00);
    else if (is_branch)          misalign = br_taken && (alu_res[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cause_d     = cause_q;
    rf_we       = 1'b0;
    rf_wdata    = alu_q;
    next_pc     = pc_plus4;
    case (state_q)
      StFetch: begin
        // Raising mem_req takes a cycle only on the first fetch after reset.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem_ready) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        a_d   = rf_q[rs1[RW-1:0]];
        b_d   = rf_q[rs2[RW-1:0]];
        imm_d = imm_gen;
        if (is_sys) begin
          cause_d = TrapSystem;
          state_d = StHalt;
        end else if (!legal) begin
          cause_d = TrapIllegal;
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (misalign) begin
          cause_d = TrapMisalign;
          state_d = StHalt;
        end else if (is_branch) begin
          next_pc    = br_taken ? alu_res : pc_plus4;
          pc_d       = next_pc;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = next_pc;
          state_d    = StFetch;
        end else if (is_load || is_store) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = alu_res;
          mem_wdata_d = b_q;
          state_d     = StMem;
        end else begin
          alu_d   = target;
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ready) begin
          if (is_store) begin
            pc_d       = pc_plus4;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_plus4;
            state_d    = StFetch;
          end else begin
            mdr_d     = mem_rdata;
            mem_req_d = 1'b0;
            state_d   = StWb;
          end
        end
      end
      StWb: begin
        rf_we      = (rd != 5'd0);
        rf_wdata   = (is_jal || is_jalr) ? pc_plus4 : (is_load ? mdr_q : alu_q);
        next_pc    = (is_jal || is_jalr) ? alu_q : pc_plus4;
        pc_d       = next_pc;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = next_pc;
        state_d    = StFetch;
      end
      StHalt: ;
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      StWb:    retire = 1'b1;
      StExec:  retire = is_branch && !misalign;
      StMem:   retire = is_store && mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= '0;
      cause_q     <= TrapNone;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cause_q     <= cause_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd[RW-1:0]] <= rf_wdata;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pc         = pc_q;
  assign halted     = (state_q == StHalt);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: small programs in a word memory whose data
// region (>= 0x40) answers after three wait cycles.
module tb_multicycle_cpu;

  localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [1:0]  trap_cause;

  logic [31:0] mem [64];
  logic [31:0] img [64];
  logic        do_load = 1'b0;
  logic        data_stall = 1'b0;
  logic        is_data;
  int          wait_cnt = 0;

  int          cyc = 0;
  int          ret_n = 0;
  int          ret_cyc [32];
  int          data_reqs = 0;
  int          stab_bad = 0;
  logic        hold = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;

  int total = 0;
  int bad = 0;

  multicycle_cpu #(.XLEN(32), .RESET_PC(32'h0000_0000), .NREGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .retire     (retire),
    .pc         (pc),
    .halted     (halted),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  assign is_data   = (mem_addr >= 32'h40);
  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ready = mem_req && (!is_data || (!data_stall && wait_cnt == 3));

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
  end

  // Retire timestamps, data-request count and request-stability tracking.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      ret_n     <= 0;
      data_reqs <= 0;
      hold      <= 1'b0;
    end else begin
      if (retire && ret_n < 32) begin
        ret_cyc[ret_n] <= cyc;
        ret_n          <= ret_n + 1;
      end
      if (mem_req && is_data) data_reqs <= data_reqs + 1;
      if (hold && (!mem_req || mem_addr != h_addr || mem_we != h_we || mem_wdata != h_wdata))
        stab_bad <= stab_bad + 1;
      hold    <= mem_req && !mem_ready;
      h_addr  <= mem_addr;
      h_we    <= mem_we;
      h_wdata <= mem_wdata;
    end
  end

  function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] u_t(input logic [31:0] imm, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm[19:0], rd, op};
  endfunction

  function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (!halted && k < 600) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'b0, halted}, 32'd1);
  endtask

  task automatic wait_ret(input int n, input string tag);
    int k = 0;
    while (ret_n < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'b0, ret_n >= n}, 32'd1);
  endtask

  initial begin
    int k;
    logic any;

    // Reset values with the clock not yet having ticked.
    #1 rst = 1'b0;
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_cause", {30'b0, trap_cause}, 32'd0);

    // ALU mix, then SW/LW through the slow data region, then ECALL.
    clear_img();
    img[0]  = i_t(32'd5, 5'd0, 3'd0, 5'd1, OP_IMM);
    img[1]  = i_t(-32'sd3, 5'd0, 3'd0, 5'd2, OP_IMM);
    img[2]  = r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    img[3]  = r_t(7'h20, 5'd1, 5'd2, 3'd0, 5'd7);
    img[4]  = r_t(7'h00, 5'd1, 5'd2, 3'd2, 5'd8);
    img[5]  = r_t(7'h00, 5'd1, 5'd2, 3'd3, 5'd9);
    img[6]  = i_t(32'h401, 5'd2, 3'd5, 5'd10, OP_IMM);
    img[7]  = i_t(32'd28, 5'd2, 3'd5, 5'd11, OP_IMM);
    img[8]  = r_t(7'h00, 5'd2, 5'd1, 3'd4, 5'd12);
    img[9]  = u_t(32'h12345, 5'd13, OP_LUI);
    img[10] = u_t(32'h1, 5'd14, OP_AUIPC);
    img[11] = s_t(32'h40, 5'd3, 5'd0);
    img[12] = i_t(32'h40, 5'd0, 3'd2, 5'd4, OP_LOAD);
    img[13] = 32'h0000_0073;
    do_reset();
    wait_halt("p1_halt");
    check("p1_add_x3", dut.rf_q[3], 32'd2);
    check("p1_sub_x7", dut.rf_q[7], 32'hFFFF_FFF8);
    check("p1_slt_x8", dut.rf_q[8], 32'd1);
    check("p1_sltu_x9", dut.rf_q[9], 32'd0);
    check("p1_srai_x10", dut.rf_q[10], 32'hFFFF_FFFE);
    check("p1_srli_x11", dut.rf_q[11], 32'h0000_000F);
    check("p1_xor_x12", dut.rf_q[12], 32'hFFFF_FFF8);
    check("p1_lui_x13", dut.rf_q[13], 32'h1234_5000);
    check("p1_auipc_x14", dut.rf_q[14], 32'h0000_1028);
    check("p1_lw_x4", dut.rf_q[4], 32'd2);
    check("p1_store_mem", mem[16], 32'd2);
    check("p1_cause", {30'b0, trap_cause}, 32'd1);
    check("p1_pc", pc, 32'h34);
    check("p1_no_retire_halt", {31'b0, retire}, 32'd0);
    check("p1_ret_count", ret_n, 32'd13);
    check("p1_alu_lat_a", ret_cyc[1] - ret_cyc[0], 32'd4);
    check("p1_alu_lat_b", ret_cyc[2] - ret_cyc[1], 32'd4);
    check("p1_sw_lat", ret_cyc[11] - ret_cyc[10], 32'd7);
    check("p1_lw_lat", ret_cyc[12] - ret_cyc[11], 32'd8);

    // Count-down loop with BNE back 8 bytes, ended by EBREAK.
    clear_img();
    img[0] = i_t(32'd3, 5'd0, 3'd0, 5'd5, OP_IMM);
    img[1] = i_t(32'd1, 5'd6, 3'd0, 5'd6, OP_IMM);
    img[2] = i_t(-32'sd1, 5'd5, 3'd0, 5'd5, OP_IMM);
    img[3] = b_t(-32'sd8, 5'd0, 5'd5, 3'd1);
    img[4] = 32'h0010_0073;
    do_reset();
    wait_halt("p2_halt");
    check("p2_x5", dut.rf_q[5], 32'd0);
    check("p2_iters_x6", dut.rf_q[6], 32'd3);
    check("p2_ret_count", ret_n, 32'd10);
    check("p2_branch_lat", ret_cyc[3] - ret_cyc[2], 32'd3);
    check("p2_after_branch_lat", ret_cyc[4] - ret_cyc[3], 32'd4);
    check("p2_cause", {30'b0, trap_cause}, 32'd1);
    check("p2_pc", pc, 32'h10);

    // JAL x1,+12 at 0x10 and JALR x0,1(x1) which must clear bit 0.
    clear_img();
    for (int i = 0; i < 4; i++) img[i] = i_t(32'd0, 5'd0, 3'd0, 5'd0, OP_IMM);
    img[4] = j_t(32'd12, 5'd1);
    img[5] = 32'h0000_0073;
    img[6] = i_t(32'd0, 5'd0, 3'd0, 5'd0, OP_IMM);
    img[7] = i_t(32'd1, 5'd1, 3'd0, 5'd0, OP_JALR);
    do_reset();
    wait_ret(5, "p3_jal_retired");
    check("p3_jal_pc", pc, 32'h1C);
    check("p3_jal_link", dut.rf_q[1], 32'h14);
    wait_halt("p3_halt");
    check("p3_jalr_pc", pc, 32'h14);
    check("p3_cause", {30'b0, trap_cause}, 32'd1);
    check("p3_ret_count", ret_n, 32'd6);

    // Misaligned load: no data request, cause 3.
    clear_img();
    img[0] = i_t(32'h42, 5'd0, 3'd2, 5'd2, OP_LOAD);
    do_reset();
    wait_halt("p4_halt");
    check("p4_cause", {30'b0, trap_cause}, 32'd3);
    check("p4_pc", pc, 32'h0);
    check("p4_no_data_req", data_reqs, 32'd0);
    check("p4_ret_count", ret_n, 32'd0);

    // Opcode 0 is illegal.
    clear_img();
    do_reset();
    wait_halt("p5_halt");
    check("p5_cause", {30'b0, trap_cause}, 32'd2);
    check("p5_pc", pc, 32'h0);

    // Misaligned jump target: no link written.
    clear_img();
    img[0] = j_t(32'd6, 5'd1);
    do_reset();
    wait_halt("p7_halt");
    check("p7_cause", {30'b0, trap_cause}, 32'd3);
    check("p7_no_link", dut.rf_q[1], 32'd0);

    // Reset pulsed in the middle of a stalled store.
    clear_img();
    img[0] = i_t(32'd7, 5'd0, 3'd0, 5'd1, OP_IMM);
    img[1] = s_t(32'h40, 5'd1, 5'd0);
    img[2] = 32'h0000_0073;
    data_stall = 1'b1;
    do_reset();
    k = 0;
    while (!(mem_req && mem_we) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("p6_store_req", {31'b0, mem_req && mem_we}, 32'd1);
    @(negedge clk);
    check("p6_x1_before", dut.rf_q[1], 32'd7);
    #2 rst = 1'b0;
    #1;
    check("p6_req_drop", {31'b0, mem_req}, 32'd0);
    check("p6_pc_reset", pc, 32'h0);
    check("p6_not_halted", {31'b0, halted}, 32'd0);
    any = 1'b0;
    for (int i = 1; i < 32; i++) any = any | (|dut.rf_q[i]);
    check("p6_regs_clear", {31'b0, any}, 32'd0);
    data_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("p6_refetch_req", {31'b0, mem_req}, 32'd1);
    check("p6_refetch_addr", mem_addr, 32'h0);

    check("req_stability", stab_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Multi-cycle RV32I-subset processor core: the parametrised successor to the single-cycle CPU top. One unified memory port with a ready handshake serves both instruction fetch and data access, so the core tolerates wait-state memories. Each instruction is sequenced by an FSM through fetch, decode, execute, memory and write-back. The core halts cleanly on system instructions and on faults, and reports the cause.

## Interface
- `XLEN`, 32: datapath and register width; only 32 is supported for RV32I semantics.
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset; must be word-aligned.
- `NREGS`, 32: architectural register count, 16 or 32; `rd`/`rs` indices at or above `NREGS` are illegal.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = store, 0 = fetch/load.
- `mem_addr`  out  XLEN  byte address, always word-aligned.
- `mem_wdata`  out  XLEN  store data.
- `mem_rdata`  in  XLEN  fetch/load data, valid when `mem_ready` is high.
- `mem_ready`  in  1  completes the current request at this edge.
- `retire`  out  1  one-cycle pulse, asserted in the final cycle of each completed instruction.
- `pc`  out  XLEN  address of the instruction in flight.
- `halted`  out  1  core is stopped.
- `trap_cause`  out  2  0 none, 1 ECALL/EBREAK, 2 illegal instruction, 3 misaligned access/target.

## Operation
- Supported instructions:
  - ADD SUB AND OR XOR SLL SRL SRA SLT SLTU, plus the immediate forms.
  - LUI, AUIPC, JAL, JALR.
  - BEQ BNE BLT BGE BLTU BGEU.
  - LW, SW, ECALL, EBREAK.
- Any other opcode or funct combination is an illegal instruction and traps.
- FSM states:
  - FETCH: request at `pc`; on `mem_ready`, latch `mem_rdata` into IR.
  - DECODE: read rs1/rs2 into A/B; generate the immediate; check legality.
  - EXEC: run the ALU or compare; compute the next PC.
  - MEM: load or store at the ALU result; on `mem_ready`, latch load data.
  - WB: write rd and update PC.
  - HALT: terminal.
- Transitions out of EXEC:
  - ALU, LUI, AUIPC, JAL, JALR → WB.
  - LW and SW → MEM.
  - Branch → FETCH (retire, PC updated).
- Transitions out of MEM: LW → WB; SW → FETCH (retire on completion).
- DECODE goes to HALT on illegal, ECALL or EBREAK. `pc` holds the faulting address; no retire.
- EXEC goes to HALT with cause 3 when:
  - a load/store address has `[1:0]` ≠ 0, or
  - a taken branch or jump target has `[1:0]` ≠ 0.
  - No memory request is issued and no register is written.
- HALT is left only by reset.
- Register semantics:
  - x0 reads as zero; writes to x0 are discarded.
  - JAL/JALR write `pc`+4 to rd.
  - JALR target = (rs1 + imm) with bit 0 cleared.
- Arithmetic:
  - All arithmetic wraps modulo 2^XLEN.
  - Shift amount = low 5 bits.
  - SLT is signed; SLTU is unsigned.

## Timing
- Reset (async assert, output values take effect immediately):
  - `mem_req`=0, `mem_we`=0, `mem_addr`=`RESET_PC`, `mem_wdata`=0.
  - `retire`=0, `pc`=`RESET_PC`, `halted`=0, `trap_cause`=0.
  - All registers = 0; state = FETCH.
- After reset release, FETCH asserts `mem_req` on the first clock.
- Handshake:
  - While `mem_req`=1, `mem_we`, `mem_addr` and `mem_wdata` are held stable until an edge that samples `mem_ready`=1.
  - `mem_req` may stay high into the next state only if that state issues a new request.
  - `mem_ready` is ignored while `mem_req`=0.
  - `mem_ready` may be tied high (zero-wait) or depend combinationally on `mem_req`.
- Zero-wait latency in cycles: ALU/LUI/AUIPC/JAL/JALR 4, LW 5, SW 4, branch 3. Each memory wait cycle adds 1.
- Reset asserted mid-transaction drops `mem_req` asynchronously; any in-flight store may or may not have completed at the memory.
- `retire` and entry into HALT are mutually exclusive in the same cycle.

## Structure
- Package `cpu_pkg` holds:
  - opcode and funct constants;
  - the ALU select enum;
  - the FSM state enum;
  - the `trap_cause` codes.
- One natural sub-module: `mc_alu`, the combinational ALU plus branch comparator, reused for address and PC+4 generation.
- The register file is inline; reset-cleared.

## Test plan
- Zero-wait: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 → x3=2; `retire` pulses every 4 cycles.
- SW x3 to 0x40, then LW x4 from 0x40, with `mem_ready` delayed 3 cycles per access → x4=2; address/data stable across waits; LW takes 8 cycles.
- BNE taken back 8 bytes, loop counting x5 down from 3 → loop exits with x5=0 after 3 iterations; branch retire every 3 cycles.
- JAL x1,+12 at pc 0x10 → x1=0x14, `pc`=0x1C; JALR x0,0(x1) → `pc`=0x14.
- LW with address 0x42 → `halted`=1, `trap_cause`=3, no `mem_req` issued. Separately, opcode 0x00 → `trap_cause`=2. ECALL → `trap_cause`=1, `pc` equals the ECALL address.
- `rst` pulsed low during a stalled store → `mem_req` falls within the same cycle; `pc`=`RESET_PC`; x1..x31=0; fetch restarts.
